data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised data memory for the core's load/store stage.
//  - Byte-addressed; handles byte, half and word accesses with byte-lane writes and sign/zero-extended loads.
//  - Flags misaligned or illegal-size accesses with an error.
//  - Uses a valid/ready request handshake and a registered 1-cycle response.
//  - After reset, an init FSM hardware-clears the array before accepting traffic.
// PARAMETERS
//  DEPTH          256                  number of 32-bit words (power of 2, >=4)
//  ADDR_W         $clog2(DEPTH)+2      byte-address width (derived; do not override)
//  CLEAR_ON_RESET 1                    1: zero every word after reset; 0: skip INIT, contents undefined
// PORTS
//  clk           in   1        clock, all state on rising edge
//  rst_n         in   1        asynchronous active-low reset
//  req_valid     in   1        request present
//  req_ready     out  1        request can be accepted this cycle
//  req_we        in   1        1 store, 0 load
//  req_size      in   2        00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned  in   1        loads: 1 zero-extend, 0 sign-extend
//  req_addr      in   ADDR_W   byte address
//  req_wdata     in   32       store data, LSB-justified
//  resp_valid    out  1        one-cycle pulse: response for the accepted request
//  resp_rdata    out  32       load result (0 for stores and errors)
//  resp_err      out  1        misaligned or illegal size; no memory update
//  init_done     out  1        high once clearing is complete
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - resp_valid=0, resp_rdata=0, resp_err=0, req_ready=0, init_done=0.
//   - init counter=0; state=INIT if CLEAR_ON_RESET else IDLE.
//  FSM states: INIT -> IDLE only.
//   - INIT: writes 0 to word[cnt] each cycle, cnt 0..DEPTH-1; req_ready=0.
//   - After the write to DEPTH-1, next cycle goes to IDLE with init_done=1. INIT lasts exactly DEPTH cycles.
//   - IDLE: req_ready=1, init_done=1. With CLEAR_ON_RESET=0, IDLE is entered on the first edge after reset release.
//  Accept: req_valid && req_ready at a rising edge.
//   - Exactly one cycle later: resp_valid=1, otherwise 0.
//   - Back-to-back accepts give back-to-back responses; no response backpressure.
//  Decode: word index = req_addr[ADDR_W-1:2]; lane offset = req_addr[1:0].
//  Error when any of:
//   - size=11;
//   - size=01 with addr[0]=1;
//   - size=10 with addr[1:0]!=0.
//   On error: resp_err=1, resp_rdata=0, array unchanged.
//  Store: writes only the selected lanes at the accept edge.
//   - byte: lane = offset, data = wdata[7:0].
//   - half: lanes offset, offset+1; data = wdata[15:0].
//   - word: all four lanes.
//   - resp_rdata=0.
//  Load: resp_rdata = selected lanes shifted to bit 0, extended per req_unsigned.
//   - Word loads ignore req_unsigned.
//  Read-after-write: a load accepted the cycle after a store to the same word returns the new data.
//  Reset mid-INIT or with a response pending: resp_valid drops immediately.
//   - The in-flight request is lost.
//   - INIT restarts from word 0.
//  Address space is exactly DEPTH*4 bytes; no out-of-range case exists.
// TESTING
//  1. Reset, DEPTH=256, CLEAR_ON_RESET=1 -> req_ready=0 for 256 cycles, then init_done=1; word loads of 0x000 and 0x3FC return 0.
//  2. Store word 0xDEADBEEF @0x10; load byte @0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half @0x10 signed -> 0xFFFFBEEF.
//  3. Store byte 0x5A @0x21 over word 0x11223344 @0x20 -> word load @0x20 = 0x11225A44.
//  4. Load half @0x11, load word @0x22, size=11 @0x00 -> each: resp_err=1, resp_rdata=0; the same accesses as stores leave memory unchanged.
//  5. Store @0x40 then load @0x40 on consecutive cycles -> two consecutive resp_valid pulses; the load returns the stored value.
//  6. Assert rst_n=0 at INIT count 100 -> outputs at reset values immediately; after release, INIT runs a full 256 cycles; a previously written word reads 0.

Source files
------------

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus of the load/store data memory.
// Master issues requests; slave answers one cycle later.
interface data_memory_ctrl_if #(
  parameter int ADDR_W = 10
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with lane writes, extended loads,
// alignment errors, 1-cycle response and post-reset clearing.
module data_memory_ctrl #(
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = $clog2(DEPTH) + 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  data_memory_ctrl_if.slave  bus,
  output logic               init_done
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               rdy_q, rdy_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               resp_err_q, resp_err_d;

  logic [31:0]        mem [DEPTH];

  logic               accept;
  logic [IDX_W-1:0]   word_idx;
  logic [1:0]         off;
  logic               dec_err;
  logic [3:0]         lane_be;
  logic [31:0]        lane_wdata;
  logic [31:0]        rword;
  logic [31:0]        rshift;
  logic [31:0]        load_val;

  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata;

  assign accept   = bus.req_valid && rdy_q;
  assign word_idx = bus.req_addr[ADDR_W-1:2];
  assign off      = bus.req_addr[1:0];
  assign rword    = mem[word_idx];
  assign rshift   = rword >> {off, 3'b000};

  // Size/alignment decode, lane enables and load extension
  always_comb begin
    dec_err    = 1'b0;
    lane_be    = 4'b0000;
    lane_wdata = bus.req_wdata;
    load_val   = 32'h0;
    unique case (bus.req_size)
      2'b00: begin
        lane_be    = 4'b0001 << off;
        lane_wdata = {4{bus.req_wdata[7:0]}};
        load_val   = bus.req_unsigned
                   ? {24'h0, rshift[7:0]}
                   : {{24{rshift[7]}}, rshift[7:0]};
      end
      2'b01: begin
        dec_err    = off[0];
        lane_be    = 4'b0011 << off;
        lane_wdata = {2{bus.req_wdata[15:0]}};
        load_val   = bus.req_unsigned
                   ? {16'h0, rshift[15:0]}
                   : {{16{rshift[15]}}, rshift[15:0]};
      end
      2'b10: begin
        dec_err    = (off != 2'b00);
        lane_be    = 4'b1111;
        load_val   = rword;
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Next state: clear sweep, request accept and response build
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mem_we       = 1'b0;
    mem_idx      = word_idx;
    mem_be       = 4'b0000;
    mem_wdata    = lane_wdata;
    resp_valid_d = accept;
    resp_rdata_d = 32'h0;
    resp_err_d   = 1'b0;
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_idx   = cnt_q;
      mem_be    = 4'b1111;
      mem_wdata = 32'h0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == IDX_W'(DEPTH - 1))
        state_d = IDLE;
    end else if (accept) begin
      resp_err_d = dec_err;
      if (!dec_err) begin
        if (bus.req_we) begin
          mem_we = 1'b1;
          mem_be = lane_be;
        end else begin
          resp_rdata_d = load_val;
        end
      end
    end
    rdy_d = (state_d == IDLE);
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR_ON_RESET ? INIT : IDLE;
      cnt_q        <= '0;
      rdy_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rdy_q        <= rdy_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Storage array, byte-lane write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b])
          mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign bus.req_ready  = rdy_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign init_done      = rdy_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: directed vector table, reset
// corner sequences and a random stream against a byte model.
module tb_data_memory_ctrl;
  logic clk;
  logic rst_n;
  logic init_done;
  int   checks;
  int   errors;

  data_memory_ctrl_if #(.ADDR_W(10)) bus ();

  data_memory_ctrl #(
    .DEPTH(256),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ref_mem [1024];

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(logic we, logic [1:0] sz, logic uns,
                              logic [9:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic er);
    vec_t v;
    v.we = we; v.sz = sz; v.uns = uns; v.addr = a;
    v.wd = wd; v.rd = rd; v.er = er;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: an access touches 2**size bytes, little-endian
  function automatic void model(input logic we, input logic [1:0] sz,
                                input logic uns, input int addr,
                                input logic [31:0] wd,
                                output logic [31:0] rd,
                                output logic er);
    int n;
    logic [31:0] v;
    n  = 1 << sz;
    rd = 32'h0;
    er = (sz == 2'b11) || ((addr % n) != 0);
    if (er) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[addr + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++)
        v = v | ({24'h0, ref_mem[addr + i]} << (8 * i));
      if (!uns && n < 4 && v[8*n-1])
        v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic drive(logic we, logic [1:0] sz, logic uns,
                       logic [9:0] a, logic [31:0] wd);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
  endtask

  task automatic idle_bus();
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = 32'h0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.req_ready) break;
    end
  endtask

  task automatic check_reset_outs(string tag);
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_done"}, 32'(init_done), 32'h0);
    chk({tag, "_valid"}, 32'(bus.resp_valid), 32'h0);
    chk({tag, "_rdata"}, bus.resp_rdata, 32'h0);
    chk({tag, "_err"}, 32'(bus.resp_err), 32'h0);
  endtask

  logic [31:0] erd;
  logic        eer;
  logic [31:0] pend_rd;
  logic        pend_er;
  logic        pend;
  int          n;

  initial begin
    checks = 0;
    errors = 0;
    clear_model();
    idle_bus();
    rst_n = 1'b0;
    #2;
    check_reset_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init(n);
    chk("init_len", 32'(n), 32'd256);
    chk("init_done", 32'(init_done), 32'h1);

    vecs[0]  = mk(0, 2'b10, 0, 10'h000, 0, 32'h0, 0);
    vecs[1]  = mk(0, 2'b10, 0, 10'h3FC, 0, 32'h0, 0);
    vecs[2]  = mk(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0);
    vecs[3]  = mk(0, 2'b00, 0, 10'h013, 0, 32'hFFFFFFDE, 0);
    vecs[4]  = mk(0, 2'b00, 1, 10'h013, 0, 32'h000000DE, 0);
    vecs[5]  = mk(0, 2'b01, 0, 10'h010, 0, 32'hFFFFBEEF, 0);
    vecs[6]  = mk(1, 2'b10, 0, 10'h020, 32'h11223344, 32'h0, 0);
    vecs[7]  = mk(1, 2'b00, 0, 10'h021, 32'hFFFFFF5A, 32'h0, 0);
    vecs[8]  = mk(0, 2'b10, 0, 10'h020, 0, 32'h11225A44, 0);
    vecs[9]  = mk(0, 2'b01, 0, 10'h011, 0, 32'h0, 1);
    vecs[10] = mk(0, 2'b10, 0, 10'h022, 0, 32'h0, 1);
    vecs[11] = mk(0, 2'b11, 0, 10'h000, 0, 32'h0, 1);
    vecs[12] = mk(1, 2'b01, 0, 10'h011, 32'hFFFFFFFF, 32'h0, 1);
    vecs[13] = mk(1, 2'b10, 0, 10'h022, 32'hFFFFFFFF, 32'h0, 1);
    vecs[14] = mk(1, 2'b11, 0, 10'h000, 32'hFFFFFFFF, 32'h0, 1);
    vecs[15] = mk(0, 2'b10, 0, 10'h010, 0, 32'hDEADBEEF, 0);
    vecs[16] = mk(0, 2'b10, 0, 10'h020, 0, 32'h11225A44, 0);
    vecs[17] = mk(0, 2'b10, 1, 10'h000, 0, 32'h0, 0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].sz, vecs[i].uns,
            vecs[i].addr, vecs[i].wd);
      model(vecs[i].we, vecs[i].sz, vecs[i].uns,
            int'(vecs[i].addr), vecs[i].wd, erd, eer);
      @(negedge clk);
      idle_bus();
      chk($sformatf("vec%0d_valid", i), 32'(bus.resp_valid), 32'h1);
      chk($sformatf("vec%0d_rdata", i), bus.resp_rdata, vecs[i].rd);
      chk($sformatf("vec%0d_err", i), 32'(bus.resp_err), 32'(vecs[i].er));
      @(negedge clk);
      chk($sformatf("vec%0d_pulse", i), 32'(bus.resp_valid), 32'h0);
    end

    // store then load same word on consecutive cycles
    @(negedge clk);
    drive(1, 2'b10, 0, 10'h040, 32'hCAFEF00D);
    model(1, 2'b10, 0, 32'h40, 32'hCAFEF00D, erd, eer);
    @(negedge clk);
    drive(0, 2'b10, 0, 10'h040, 0);
    chk("b2b_st_valid", 32'(bus.resp_valid), 32'h1);
    chk("b2b_st_rdata", bus.resp_rdata, 32'h0);
    @(negedge clk);
    idle_bus();
    chk("b2b_ld_valid", 32'(bus.resp_valid), 32'h1);
    chk("b2b_ld_rdata", bus.resp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    chk("b2b_end_valid", 32'(bus.resp_valid), 32'h0);

    // random stream with gaps, compared one cycle behind
    pend = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [9:0]  a;
      logic [31:0] wd;
      @(negedge clk);
      chk("rnd_valid", 32'(bus.resp_valid), 32'(pend));
      if (pend) begin
        chk("rnd_rdata", bus.resp_rdata, pend_rd);
        chk("rnd_err", 32'(bus.resp_err), 32'(pend_er));
      end
      if ($urandom_range(3) == 0) begin
        idle_bus();
        pend = 1'b0;
      end else begin
        we  = 1'($urandom_range(1));
        sz  = 2'($urandom_range(3));
        uns = 1'($urandom_range(1));
        a   = 10'($urandom_range(63));
        if ($urandom_range(3) != 0) a = a & ~((10'd1 << sz) - 10'd1);
        wd  = $urandom;
        drive(we, sz, uns, a, wd);
        model(we, sz, uns, int'(a), wd, pend_rd, pend_er);
        pend = 1'b1;
      end
    end
    @(negedge clk);
    idle_bus();
    chk("rnd_last_valid", 32'(bus.resp_valid), 32'(pend));
    if (pend) begin
      chk("rnd_last_rdata", bus.resp_rdata, pend_rd);
      chk("rnd_last_err", 32'(bus.resp_err), 32'(pend_er));
    end

    // reset with a response pending
    @(negedge clk);
    drive(0, 2'b10, 0, 10'h010, 0);
    @(posedge clk);
    #1;
    chk("pend_valid", 32'(bus.resp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outs("pend_rst");
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;

    // reset again in the middle of clearing
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("mid_init");
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    wait_init(n);
    chk("reinit_len", 32'(n), 32'd256);
    @(negedge clk);
    drive(0, 2'b10, 0, 10'h010, 0);
    @(negedge clk);
    idle_bus();
    chk("cleared_valid", 32'(bus.resp_valid), 32'h1);
    chk("cleared_word", bus.resp_rdata, 32'h0);
    @(negedge clk);
    drive(0, 2'b10, 0, 10'h040, 0);
    @(negedge clk);
    idle_bus();
    chk("cleared_word2", bus.resp_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
